// File: rtl/regfile_wb_scheduler.sv
// Shares the register file write port between pipeline writeback and a long-latency unit,
// and tracks outstanding long-latency destinations to stall decode on RAW/WAW hazards.
module regfile_wb_scheduler #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_PENDING  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_dec_valid,
    input  logic [4:0]  i_dec_rs,
    input  logic [4:0]  i_dec_rt,
    input  logic [4:0]  i_dec_rd,
    input  logic        i_dec_we,
    input  logic        i_dec_long,
    output logic        o_issue_stall,
    input  logic        i_p_we,
    input  logic [4:0]  i_p_rd,
    input  logic [31:0] i_p_wdata,
    output logic        o_pipe_hold,
    input  logic        i_lu_valid,
    input  logic [4:0]  i_lu_rd,
    input  logic [31:0] i_lu_wdata,
    output logic        o_lu_ready,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_waddr,
    output logic [31:0] o_rf_wdata,
    output logic [31:0] o_busy
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PEND_W = 6;

    logic [NREG-1:0]   r_busy;
    logic [PEND_W-1:0] r_pending;
    logic [CNT_W-1:0]  r_starve;
    logic              r_pipe_hold;

    logic              w_pipe_sel;
    logic              w_lu_ready;
    logic              w_transfer;
    logic              w_blocked;
    logic              w_hold_nxt;
    logic              w_set;
    logic              w_clr;
    logic              w_stall;
    logic [NREG-1:0]   w_busy_nxt;
    logic [PEND_W-1:0] w_pending_nxt;
    logic [CNT_W-1:0]  w_starve_nxt;

    // Write-port arbitration: pipeline has priority unless held for a starving long unit.
    always_comb begin
        w_lu_ready = 1'b0;
        o_rf_we    = 1'b0;
        o_rf_waddr = '0;
        o_rf_wdata = '0;
        w_pipe_sel = i_p_we && (i_p_rd != REG_W'(0)) && !r_pipe_hold;
        if (w_pipe_sel) begin
            o_rf_we    = 1'b1;
            o_rf_waddr = i_p_rd;
            o_rf_wdata = i_p_wdata;
        end else begin
            w_lu_ready = 1'b1;
            if (i_lu_valid && (i_lu_rd != REG_W'(0))) begin
                o_rf_we    = 1'b1;
                o_rf_waddr = i_lu_rd;
                o_rf_wdata = i_lu_wdata;
            end
        end
    end

    assign w_transfer = i_lu_valid && w_lu_ready;
    assign w_blocked  = i_lu_valid && !w_lu_ready;

    // Hold fires after STARVE_LIMIT+1 consecutive blocked cycles; the hold cycle itself always transfers.
    always_comb begin
        w_starve_nxt = '0;
        w_hold_nxt   = 1'b0;
        if (w_blocked) begin
            w_starve_nxt = r_starve + CNT_W'(1);
            w_hold_nxt   = (r_starve == CNT_W'(STARVE_LIMIT));
        end
    end

    always_comb begin
        w_stall = 1'b0;
        if (i_dec_valid) begin
            w_stall = r_busy[i_dec_rs] || r_busy[i_dec_rt] ||
                      (i_dec_we && r_busy[i_dec_rd]) ||
                      (i_dec_long && (r_pending == PEND_W'(MAX_PENDING)));
        end
    end

    assign w_set = i_dec_valid && i_dec_long && i_dec_we &&
                   (i_dec_rd != REG_W'(0)) && !w_stall;
    assign w_clr = w_transfer && r_busy[i_lu_rd];

    // Set and clear never target the same register: an accepted issue requires its rd to be idle.
    always_comb begin
        w_busy_nxt    = r_busy;
        w_pending_nxt = r_pending;
        if (w_set) begin
            w_busy_nxt[i_dec_rd] = 1'b1;
        end
        if (w_clr) begin
            w_busy_nxt[i_lu_rd] = 1'b0;
        end
        case ({w_set, w_clr})
            2'b10:   w_pending_nxt = r_pending + PEND_W'(1);
            2'b01:   w_pending_nxt = r_pending - PEND_W'(1);
            default: w_pending_nxt = r_pending;
        endcase
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy      <= '0;
            r_pending   <= '0;
            r_starve    <= '0;
            r_pipe_hold <= 1'b0;
        end else begin
            r_busy      <= w_busy_nxt;
            r_pending   <= w_pending_nxt;
            r_starve    <= w_starve_nxt;
            r_pipe_hold <= w_hold_nxt;
        end
    end

    assign o_issue_stall = w_stall;
    assign o_lu_ready    = w_lu_ready;
    assign o_pipe_hold   = r_pipe_hold;
    assign o_busy        = r_busy;

    logic [DATA_W-1:0] w_unused_width_ref;
    assign w_unused_width_ref = '0;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: a combinational arbitration table plus
// hand-written multi-cycle sequences for scoreboard, starvation and reset behaviour.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid, dec_we, dec_long;
    logic [4:0]  dec_rs, dec_rt, dec_rd;
    logic        issue_stall;
    logic        p_we;
    logic [4:0]  p_rd;
    logic [31:0] p_wdata;
    logic        pipe_hold;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;

    int total = 0;
    int bad   = 0;

    regfile_wb_scheduler #(.STARVE_LIMIT(4), .MAX_PENDING(4)) dut (
        .clk(clk), .reset(reset),
        .i_dec_valid(dec_valid), .i_dec_rs(dec_rs), .i_dec_rt(dec_rt), .i_dec_rd(dec_rd),
        .i_dec_we(dec_we), .i_dec_long(dec_long), .o_issue_stall(issue_stall),
        .i_p_we(p_we), .i_p_rd(p_rd), .i_p_wdata(p_wdata), .o_pipe_hold(pipe_hold),
        .i_lu_valid(lu_valid), .i_lu_rd(lu_rd), .i_lu_wdata(lu_wdata), .o_lu_ready(lu_ready),
        .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        p_we;
        logic [4:0]  p_rd;
        logic [31:0] p_wdata;
        logic        lu_valid;
        logic [4:0]  lu_rd;
        logic [31:0] lu_wdata;
        logic        dec_valid;
        logic [4:0]  dec_rs;
        logic        dec_long;
        logic [4:0]  dec_rd;
        logic        dec_we;
        logic        e_rf_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_lu_ready;
        logic        e_stall;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        dec_valid = 1'b0; dec_we = 1'b0; dec_long = 1'b0;
        dec_rs = 5'd0; dec_rt = 5'd0; dec_rd = 5'd0;
        p_we = 1'b0; p_rd = 5'd0; p_wdata = 32'd0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_wdata = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic long_op(input logic [4:0] rd);
        idle();
        dec_valid = 1'b1; dec_long = 1'b1; dec_we = 1'b1; dec_rd = rd;
    endtask

    task automatic lu_offer(input logic [4:0] rd, input logic [31:0] d);
        lu_valid = 1'b1; lu_rd = rd; lu_wdata = d;
    endtask

    initial begin
        int drain[4];
        vt[0] = '{1'b1, 5'd3,  32'hA0A00001, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b1, 5'd3,  32'hA0A00001, 1'b0, 1'b0};
        vt[1] = '{1'b1, 5'd3,  32'hA0A00002, 1'b1, 5'd5,  32'hB0B00001, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b1, 5'd3,  32'hA0A00002, 1'b0, 1'b0};
        vt[2] = '{1'b1, 5'd0,  32'hA0A00003, 1'b1, 5'd7,  32'hB0B00002, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b1, 5'd7,  32'hB0B00002, 1'b1, 1'b0};
        vt[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hB0B00003, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
        vt[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
        vt[5] = '{1'b1, 5'd0,  32'hA0A00004, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
        vt[6] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd8, 1'b1, 5'd9, 1'b1,
                  1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
        vt[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'h5555AAAA, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0};

        idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", busy, 32'h0);
        chk("reset_hold", 32'(pipe_hold), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Combinational arbitration table, state idle; inputs withdrawn before each edge.
        for (int i = 0; i < 8; i++) begin
            p_we = vt[i].p_we; p_rd = vt[i].p_rd; p_wdata = vt[i].p_wdata;
            lu_valid = vt[i].lu_valid; lu_rd = vt[i].lu_rd; lu_wdata = vt[i].lu_wdata;
            dec_valid = vt[i].dec_valid; dec_rs = vt[i].dec_rs; dec_rt = 5'd0;
            dec_long = vt[i].dec_long; dec_rd = vt[i].dec_rd; dec_we = vt[i].dec_we;
            #1;
            chk($sformatf("vec%0d_rf_we", i), 32'(rf_we), 32'(vt[i].e_rf_we));
            chk($sformatf("vec%0d_lu_ready", i), 32'(lu_ready), 32'(vt[i].e_lu_ready));
            chk($sformatf("vec%0d_stall", i), 32'(issue_stall), 32'(vt[i].e_stall));
            if (vt[i].e_rf_we) begin
                chk($sformatf("vec%0d_waddr", i), 32'(rf_waddr), 32'(vt[i].e_waddr));
                chk($sformatf("vec%0d_wdata", i), rf_wdata, vt[i].e_wdata);
            end
            idle();
            tick();
        end
        chk("table_busy", busy, 32'h0);

        // Long op to $8, RAW stall, then clear by transfer.
        long_op(5'd8);
        #1 chk("issue8_stall", 32'(issue_stall), 32'h0);
        tick();
        idle(); dec_valid = 1'b1; dec_rs = 5'd8;
        lu_offer(5'd8, 32'h12345678);
        #1;
        chk("raw8_busy", busy, 32'h00000100);
        chk("raw8_stall", 32'(issue_stall), 32'h1);
        chk("lu8_rf_we", 32'(rf_we), 32'h1);
        chk("lu8_waddr", 32'(rf_waddr), 32'd8);
        chk("lu8_wdata", rf_wdata, 32'h12345678);
        chk("lu8_ready", 32'(lu_ready), 32'h1);
        tick();
        idle(); dec_valid = 1'b1; dec_rs = 5'd8;
        #1;
        chk("clr8_busy", busy, 32'h0);
        chk("clr8_stall", 32'(issue_stall), 32'h0);
        idle();
        tick();

        // Pending limit.
        for (int r = 1; r <= 4; r++) begin
            long_op(5'(r));
            #1 chk($sformatf("fill%0d_stall", r), 32'(issue_stall), 32'h0);
            tick();
        end
        long_op(5'd6);
        #1;
        chk("full_busy", busy, 32'h0000001E);
        chk("full_stall", 32'(issue_stall), 32'h1);
        tick();
        #1 chk("full_stall2", 32'(issue_stall), 32'h1);
        lu_offer(5'd1, 32'h11111111);
        #1 chk("full_clr_same_stall", 32'(issue_stall), 32'h1);
        tick();
        lu_valid = 1'b0;
        #1;
        chk("after_clr_busy", busy, 32'h0000001C);
        chk("after_clr_stall", 32'(issue_stall), 32'h0);
        tick();
        long_op(5'd7);
        #1;
        chk("issue6_busy", busy, 32'h0000005C);
        chk("pending4_stall", 32'(issue_stall), 32'h1);
        drain = '{2, 3, 4, 6};
        for (int k = 0; k < 4; k++) begin
            idle();
            lu_offer(5'(drain[k]), 32'h0);
            tick();
        end
        idle();
        #1 chk("drain_busy", busy, 32'h0);

        // Same-cycle set of $9 and clear of $8; pending must stay at 1.
        long_op(5'd8);
        tick();
        long_op(5'd9);
        lu_offer(5'd8, 32'h88888888);
        #1 chk("setclr_stall", 32'(issue_stall), 32'h0);
        tick();
        idle();
        #1 chk("setclr_busy", busy, 32'h00000200);
        for (int r = 1; r <= 3; r++) begin
            long_op(5'(r));
            #1 chk($sformatf("pend_fill%0d_stall", r), 32'(issue_stall), 32'h0);
            tick();
        end
        long_op(5'd4);
        #1 chk("pend_full_stall", 32'(issue_stall), 32'h1);
        drain = '{9, 1, 2, 3};
        for (int k = 0; k < 4; k++) begin
            idle();
            lu_offer(5'(drain[k]), 32'h0);
            tick();
        end
        idle();
        #1 chk("drain2_busy", busy, 32'h0);

        // Transfers to $0 and to a non-busy register leave the scoreboard alone.
        long_op(5'd10);
        tick();
        idle();
        lu_offer(5'd0, 32'hDEADBEEF);
        #1;
        chk("lu0_rf_we", 32'(rf_we), 32'h0);
        chk("lu0_ready", 32'(lu_ready), 32'h1);
        tick();
        idle();
        lu_offer(5'd11, 32'hCAFEF00D);
        #1;
        chk("lu0_busy", busy, 32'h00000400);
        chk("lu11_waddr", 32'(rf_waddr), 32'd11);
        tick();
        idle();
        #1 chk("lu11_busy", busy, 32'h00000400);
        lu_offer(5'd10, 32'h0);
        tick();
        idle();
        #1 chk("drain3_busy", busy, 32'h0);

        // Starvation: pipeline wins five cycles, hold on the sixth, pipeline resumes.
        p_we = 1'b1; p_rd = 5'd3; p_wdata = 32'h33333333;
        lu_offer(5'd5, 32'h55555555);
        for (int c = 0; c <= 6; c++) begin
            #1;
            chk($sformatf("starve_c%0d_hold", c), 32'(pipe_hold), (c == 5) ? 32'h1 : 32'h0);
            chk($sformatf("starve_c%0d_waddr", c), 32'(rf_waddr), (c == 5) ? 32'd5 : 32'd3);
            chk($sformatf("starve_c%0d_ready", c), 32'(lu_ready), (c == 5) ? 32'h1 : 32'h0);
            tick();
        end
        idle();
        tick();

        // Reset during a held transfer with busy=0x0F00.
        for (int r = 8; r <= 11; r++) begin
            long_op(5'(r));
            tick();
        end
        idle();
        #1 chk("pre_rst_busy", busy, 32'h00000F00);
        p_we = 1'b1; p_rd = 5'd3; p_wdata = 32'h33333333;
        lu_offer(5'd8, 32'h87654321);
        for (int c = 0; c < 5; c++) tick();
        #1 chk("pre_rst_hold", 32'(pipe_hold), 32'h1);
        dec_valid = 1'b1; dec_rs = 5'd8;
        reset = 1'b1;
        #1;
        chk("rst_busy", busy, 32'h0);
        chk("rst_hold", 32'(pipe_hold), 32'h0);
        chk("rst_stall", 32'(issue_stall), 32'h0);
        chk("rst_lu_ready", 32'(lu_ready), 32'h0);
        tick();
        reset = 1'b0;
        p_we = 1'b0; dec_valid = 1'b0;
        #1;
        chk("post_rst_rf_we", 32'(rf_we), 32'h1);
        chk("post_rst_waddr", 32'(rf_waddr), 32'd8);
        tick();
        idle();
        #1 chk("post_rst_busy", busy, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
